// File: rtl/spi_xfer_engine_pkg.sv
// Shared AXI-to-SPI bridge definitions: transfer FSM encoding, SPI mode and
// widths agreed with the slave-select queue.
package spi_xfer_engine_pkg;

    localparam int unsigned SLAVE_ADDR_W    = 8;
    localparam int unsigned DEFAULT_CLK_DIV = 2;
    // {CPOL, CPHA}; the engine only implements mode 0
    localparam logic [1:0]  SPI_MODE        = 2'd0;
    localparam logic        SCLK_IDLE       = SPI_MODE[1];

    typedef enum logic [3:0] {
        IDLE,
        POP,
        WAIT_Q,
        LATCH,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        DONE,
        GAP
    } xfer_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI engine: paces every timed phase and owns the
// registered SCLK level with one-cycle rise/fall strobes on phase entry.
module spi_sclk_gen
    import spi_xfer_engine_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic set_hi,
    input  logic set_lo,
    output logic phase_done,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // The counter wraps on phase_done so back-to-back phases stay aligned.
    assign phase_done = run && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
            sclk <= SCLK_IDLE;
        end else begin
            if (!run || phase_done)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            rise <= set_hi;
            fall <= set_lo;
            if (set_hi)
                sclk <= 1'b1;
            else if (set_lo)
                sclk <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_xfer_engine.sv
// Pops a slave address from the slave-select queue, pairs it with a TX byte and
// runs one SPI mode-0 MSB-first transfer, returning the received byte.
module spi_xfer_engine
    import spi_xfer_engine_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    q_empty,
    output logic                    q_rd_en,
    input  logic [SLAVE_ADDR_W-1:0] q_slave_addr,
    input  logic                    tx_valid,
    input  logic [DATA_W-1:0]       tx_data,
    output logic                    tx_ready,
    output logic                    rx_valid,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    rx_err,
    output logic                    busy,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic [NUM_SLAVES-1:0]   cs_n
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    xfer_state_t       state;
    logic [DATA_W-2:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [BIT_W-1:0]  bit_cnt;
    logic              run;
    logic              set_hi;
    logic              set_lo;
    logic              phase_done;
    logic              rise;
    logic              fall;

    always_comb begin
        run    = (state == SETUP) || (state == SHIFT_HI) || (state == SHIFT_LO) ||
                 (state == HOLD)  || (state == GAP);
        set_hi = phase_done && ((state == SETUP) || (state == SHIFT_LO));
        set_lo = phase_done && (state == SHIFT_HI);
    end

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .set_hi     (set_hi),
        .set_lo     (set_lo),
        .phase_done (phase_done),
        .rise       (rise),
        .fall       (fall),
        .sclk       (sclk)
    );

    // mosi is the top bit of the TX shift register {mosi, tx_sh}.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cs_n     <= '1;
            mosi     <= 1'b0;
            q_rd_en  <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
        end else begin
            q_rd_en  <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!q_empty && tx_valid) begin
                        state   <= POP;
                        q_rd_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                POP: state <= WAIT_Q;
                WAIT_Q: begin
                    state    <= LATCH;
                    tx_ready <= 1'b1;
                end
                LATCH: begin
                    bit_cnt <= '0;
                    rx_sh   <= '0;
                    if (32'(q_slave_addr) >= NUM_SLAVES) begin
                        tx_sh    <= tx_data[DATA_W-2:0];
                        state    <= DONE;
                        rx_valid <= 1'b1;
                        rx_err   <= 1'b1;
                        rx_data  <= '0;
                    end else begin
                        {mosi, tx_sh} <= tx_data;
                        cs_n          <= ~(NUM_SLAVES'(1) << q_slave_addr);
                        state         <= SETUP;
                    end
                end
                SETUP: if (phase_done) state <= SHIFT_HI;
                SHIFT_HI: begin
                    if (rise)
                        rx_sh <= {rx_sh[DATA_W-2:0], miso};
                    if (phase_done) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= (bit_cnt == BIT_W'(DATA_W - 1)) ? HOLD : SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (fall)
                        {mosi, tx_sh} <= {tx_sh, 1'b0};
                    if (phase_done)
                        state <= SHIFT_HI;
                end
                HOLD: begin
                    if (phase_done) begin
                        state    <= DONE;
                        cs_n     <= '1;
                        mosi     <= 1'b0;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sh;
                    end
                end
                DONE: begin
                    state  <= GAP;
                    rx_err <= 1'b0;
                end
                GAP: begin
                    if (phase_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine: default instance plus a CLK_DIV=1 instance,
// with a registered-output queue model and a mode-0 SPI slave model.
`timescale 1ns/1ps
module tb_spi_xfer_engine;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;

    // default instance (CLK_DIV=2)
    logic       q_rd_en, tx_valid, tx_ready, rx_valid, rx_err, busy, sclk, mosi, miso;
    logic [7:0] q_slave_addr, tx_data, rx_data, cs_n;
    logic [7:0] qmem [8];
    int         wr = 0;
    int         rd = 0;
    wire        q_empty = (wr == rd);

    // CLK_DIV=1 instance
    logic       q_rd_en1, tx_valid1, tx_ready1, rx_valid1, rx_err1, busy1, sclk1, mosi1, miso1;
    logic [7:0] q_slave_addr1, tx_data1, rx_data1, cs_n1;
    int         wr1 = 0;
    int         rd1 = 0;
    wire        q_empty1 = (wr1 == rd1);

    always #5 clk = ~clk;

    spi_xfer_engine #(.NUM_SLAVES(8), .CLK_DIV(2), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .q_empty(q_empty), .q_rd_en(q_rd_en),
        .q_slave_addr(q_slave_addr), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_xfer_engine #(.NUM_SLAVES(8), .CLK_DIV(1), .DATA_W(8)) dut1 (
        .clk(clk), .reset(reset), .q_empty(q_empty1), .q_rd_en(q_rd_en1),
        .q_slave_addr(q_slave_addr1), .tx_valid(tx_valid1), .tx_data(tx_data1),
        .tx_ready(tx_ready1), .rx_valid(rx_valid1), .rx_data(rx_data1), .rx_err(rx_err1),
        .busy(busy1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
    );

    // Queue head is a register loaded by the pop strobe.
    always @(posedge clk) begin
        if (q_rd_en) begin
            q_slave_addr <= qmem[rd % 8];
            rd           <= rd + 1;
        end
        if (q_rd_en1)
            rd1 <= rd1 + 1;
    end

    // Monitor and slave model for the default instance, sampled on negedge.
    logic [7:0] pat = 8'h00;
    logic [7:0] spat = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    logic [7:0] last_cs_val = 8'hFF;
    logic [7:0] prev_cs_val = 8'hFF;
    logic [7:0] last_rx = 8'h00;
    logic       last_err = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       multi_low = 1'b0;
    int         rd_pulses = 0, txr_cnt = 0, rxv_cnt = 0;
    int         cs_low_run = 0, last_cs_low = 0, cs_high_run = 0, last_gap = 0;
    int         cs_low_total = 0, sclk_hi_total = 0, rises_run = 0, last_rises = 0;

    always @(negedge clk) begin
        sclk_prev <= sclk;
        if (q_rd_en)  rd_pulses <= rd_pulses + 1;
        if (tx_ready) txr_cnt   <= txr_cnt + 1;
        if (sclk)     sclk_hi_total <= sclk_hi_total + 1;
        if (rx_valid) begin
            rxv_cnt  <= rxv_cnt + 1;
            last_rx  <= rx_data;
            last_err <= rx_err;
        end
        if ($countones(~cs_n) > 1) multi_low <= 1'b1;
        if (&cs_n) begin
            spat        <= pat;
            miso        <= pat[7];
            cs_high_run <= cs_high_run + 1;
            if (cs_low_run != 0) begin
                last_cs_low <= cs_low_run;
                last_rises  <= rises_run;
                cs_low_run  <= 0;
            end
        end else begin
            cs_low_total <= cs_low_total + 1;
            cs_low_run   <= cs_low_run + 1;
            if (cs_low_run == 0) begin
                prev_cs_val <= last_cs_val;
                last_cs_val <= cs_n;
                last_gap    <= cs_high_run;
                cs_high_run <= 0;
                rises_run   <= 0;
            end
            if (sclk && !sclk_prev) begin
                mosi_cap  <= {mosi_cap[6:0], mosi};
                rises_run <= (cs_low_run == 0) ? 1 : rises_run + 1;
            end
            if (!sclk && sclk_prev) begin
                spat <= spat << 1;
                miso <= spat[6];
            end
        end
    end

    // Monitor for the CLK_DIV=1 instance.
    logic sclk1_prev = 1'b0;
    int   rxv1_cnt = 0, cs1_run = 0, last_cs1_low = 0, per1_cnt = 0, last_per1 = 0;

    always @(negedge clk) begin
        sclk1_prev <= sclk1;
        if (rx_valid1) rxv1_cnt <= rxv1_cnt + 1;
        if (!(&cs_n1)) begin
            cs1_run <= cs1_run + 1;
        end else if (cs1_run != 0) begin
            last_cs1_low <= cs1_run;
            cs1_run      <= 0;
        end
        if (sclk1 && !sclk1_prev) begin
            last_per1 <= per1_cnt + 1;
            per1_cnt  <= 0;
        end else begin
            per1_cnt <= per1_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rx(input int target, input string tag);
        int n = 0;
        while (rxv_cnt < target && n < 500) begin
            tick();
            n++;
        end
        chk(tag, 32'(rxv_cnt >= target), 32'd1);
    endtask

    task automatic wait_rx1(input int target, input string tag);
        int n = 0;
        while (rxv1_cnt < target && n < 500) begin
            tick();
            n++;
        end
        chk(tag, 32'(rxv1_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    int b_rd, b_txr, b_rx, b_cs, b_sclk;

    initial begin
        reset     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_valid1 = 1'b0;
        tx_data1  = 8'h00;
        miso1     = 1'b0;
        q_slave_addr1 = 8'd2;
        for (int i = 0; i < 8; i++) qmem[i] = 8'h00;
        repeat (3) tick();

        // reset state
        chk("rst_cs_n",     32'(cs_n),    32'hFF);
        chk("rst_sclk",     32'(sclk),    32'd0);
        chk("rst_mosi",     32'(mosi),    32'd0);
        chk("rst_busy",     32'(busy),    32'd0);
        chk("rst_outs",     32'({q_rd_en, tx_ready, rx_valid, rx_err}), 32'd0);
        chk("rst_rx_data",  32'(rx_data), 32'd0);
        chk("rst_dut1",     32'({q_rd_en1, tx_ready1, rx_valid1, rx_err1, busy1, sclk1, mosi1}), 32'd0);
        reset = 1'b0;
        tick();

        // single transfer: addr 3, tx 0xA5, slave returns 0x3C
        qmem[0] = 8'd3; pat = 8'h3C; tx_data = 8'hA5; tx_valid = 1'b1;
        b_rd = rd_pulses; b_txr = txr_cnt; b_rx = rxv_cnt;
        wr = 1;
        wait_rx(b_rx + 1, "single_rx_timeout");
        tx_valid = 1'b0;
        tick();
        chk("single_rd_pulses", 32'(rd_pulses - b_rd), 32'd1);
        chk("single_tx_ready",  32'(txr_cnt - b_txr), 32'd1);
        chk("single_rx_data",   32'(last_rx),   32'h3C);
        chk("single_rx_err",    32'(last_err),  32'd0);
        chk("single_cs_val",    32'(last_cs_val), 32'hF7);
        chk("single_cs_low",    32'(last_cs_low), 32'd34);
        chk("single_mosi",      32'(mosi_cap),  32'hA5);
        chk("single_rises",     32'(last_rises), 32'd8);
        wait_idle("single_idle");

        // out-of-range address 9
        qmem[1] = 8'd9; tx_data = 8'h5A; tx_valid = 1'b1;
        b_txr = txr_cnt; b_rx = rxv_cnt; b_cs = cs_low_total; b_sclk = sclk_hi_total;
        wr = 2;
        wait_rx(b_rx + 1, "oor_rx_timeout");
        tx_valid = 1'b0;
        wait_idle("oor_idle");
        chk("oor_tx_ready", 32'(txr_cnt - b_txr), 32'd1);
        chk("oor_rx_err",   32'(last_err), 32'd1);
        chk("oor_rx_data",  32'(last_rx),  32'h00);
        chk("oor_cs_quiet", 32'(cs_low_total - b_cs), 32'd0);
        chk("oor_sclk_quiet", 32'(sclk_hi_total - b_sclk), 32'd0);

        // empty guard, then pop one cycle after the queue fills
        tx_valid = 1'b1; tx_data = 8'h0F; pat = 8'hC3;
        b_rd = rd_pulses;
        repeat (50) tick();
        chk("empty_no_pop", 32'(rd_pulses - b_rd), 32'd0);
        chk("empty_busy",   32'(busy), 32'd0);
        qmem[2] = 8'd5; b_rx = rxv_cnt;
        wr = 3;
        tick();
        chk("empty_pop_latency", 32'(q_rd_en), 32'd1);
        wait_rx(b_rx + 1, "empty_rx_timeout");
        tx_valid = 1'b0;
        tick();
        chk("empty_cs_val",  32'(last_cs_val), 32'hDF);
        chk("empty_rx_data", 32'(last_rx), 32'hC3);
        wait_idle("empty_idle");

        // back-to-back: addr 0 then 7, tx_valid held
        qmem[3] = 8'd0; qmem[4] = 8'd7; pat = 8'h81; tx_data = 8'h33; tx_valid = 1'b1;
        b_rd = rd_pulses; b_txr = txr_cnt; b_rx = rxv_cnt;
        wr = 5;
        wait_rx(b_rx + 2, "b2b_rx_timeout");
        tx_valid = 1'b0;
        tick();
        chk("b2b_rd_pulses", 32'(rd_pulses - b_rd), 32'd2);
        chk("b2b_tx_ready",  32'(txr_cnt - b_txr), 32'd2);
        chk("b2b_rx_valid",  32'(rxv_cnt - b_rx), 32'd2);
        chk("b2b_first_cs",  32'(prev_cs_val), 32'hFE);
        chk("b2b_second_cs", 32'(last_cs_val), 32'h7F);
        chk("b2b_gap_ge",    32'(last_gap >= 4), 32'd1);
        chk("b2b_rx_data",   32'(last_rx), 32'h81);
        wait_idle("b2b_idle");

        // CLK_DIV=1 instance: miso all ones then all zeros
        miso1 = 1'b1; tx_data1 = 8'h96; tx_valid1 = 1'b1;
        wr1 = 1;
        wait_rx1(1, "div1_rx1_timeout");
        tick();
        chk("div1_rx_ff",   32'(rx_data1), 32'hFF);
        chk("div1_cs_low",  32'(last_cs1_low), 32'd17);
        chk("div1_period",  32'(last_per1), 32'd2);
        miso1 = 1'b0;
        wr1 = 2;
        wait_rx1(2, "div1_rx2_timeout");
        tx_valid1 = 1'b0;
        tick();
        chk("div1_rx_00",   32'(rx_data1), 32'h00);
        chk("div1_rx_err",  32'(rx_err1), 32'd0);
        chk("div1_cs_low2", 32'(last_cs1_low), 32'd17);

        // asynchronous reset in the middle of SHIFT_HI
        qmem[5] = 8'd1; pat = 8'hAA; tx_data = 8'h55; tx_valid = 1'b1;
        b_rx = rxv_cnt;
        wr = 6;
        begin
            int n = 0;
            while (!sclk && n < 100) begin
                tick();
                n++;
            end
        end
        chk("midrst_reached_hi", 32'(sclk), 32'd1);
        tx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_cs_n", 32'(cs_n), 32'hFF);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("midrst_busy",   32'(busy), 32'd0);
        chk("midrst_no_rx",  32'(rxv_cnt - b_rx), 32'd0);
        chk("one_hot_cs",    32'(multi_low), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_engine.md
Name: spi_xfer_engine

Overview:
Downstream consumer of the slave-select queue in the AXI4-Lite-to-SPI bridge.
- Pops one 8-bit slave address from the queue and pairs it with one TX byte from the write-data path.
- Drives the addressed chip-select and runs one SPI mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit transfer.
- Returns the received byte to the AXI read-data path.

Parameters:
NUM_SLAVES, 8, number of chip-select lines; valid slave addresses are 0..NUM_SLAVES-1 (max 256)
CLK_DIV, 2, SCLK half-period in clk cycles (>=1)
DATA_W, 8, transfer width in bits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
q_empty  in  1  slave-select queue empty flag
q_rd_en  out  1  queue pop strobe, single-clk pulse
q_slave_addr  in  8  queue head output, valid from the cycle after q_rd_en falls
tx_valid  in  1  TX byte available
tx_data  in  DATA_W  TX byte
tx_ready  out  1  TX byte consumed (single-clk pulse)
rx_valid  out  1  transfer result valid (single-clk pulse)
rx_data  out  DATA_W  received byte
rx_err  out  1  qualifies rx_valid: addressed slave out of range
busy  out  1  high in every state except IDLE
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NUM_SLAVES  active-low chip selects, at most one low

Behaviour:
Reset (asynchronous, active-high, any state):
- state=IDLE; cs_n all 1; sclk=0; mosi=0; q_rd_en=0; tx_ready=0; rx_valid=0; rx_err=0; rx_data=0; busy=0; counters 0.
- An in-flight transfer is abandoned with no rx_valid.
States: IDLE, POP, WAIT_Q, LATCH, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE, GAP.
- IDLE: if q_empty=0 and tx_valid=1, go to POP. Otherwise stay.
- POP (1 clk): q_rd_en=1. q_rd_en is never asserted while q_empty=1 and is never held for more than 1 clk.
- WAIT_Q (1 clk): q_rd_en=0, allowing the queue output to settle.
- LATCH (1 clk):
  - Capture q_slave_addr. Pulse tx_ready=1 and load the shift register from tx_data.
  - If addr >= NUM_SLAVES: go to DONE with rx_err=1 and rx_data=0; no cs_n or sclk activity.
  - Else: drive cs_n[addr]=0, set mosi=tx_data[DATA_W-1], go to SETUP.
- SETUP (CLK_DIV clks): CS-to-first-edge setup time; sclk=0.
- SHIFT_HI (CLK_DIV clks): sclk=1. Sample miso into the RX shift register on the entry cycle, i.e. the rising edge.
- SHIFT_LO (CLK_DIV clks): sclk=0. On entry (falling edge), shift mosi to the next bit.
  - After the DATA_W-th SHIFT_HI, go to HOLD instead of SHIFT_LO. There is no trailing falling-edge shift.
- HOLD (CLK_DIV clks): sclk=0, cs_n held low.
- DONE (1 clk): cs_n all 1, rx_valid=1, rx_data = RX shift register (or 0 on error).
- GAP (CLK_DIV clks): minimum CS-high time, then return to IDLE.
Timing:
- cs_n low duration is exactly (2*DATA_W+2)*CLK_DIV - CLK_DIV clks, covering SETUP + DATA_W high phases + (DATA_W-1) low phases + HOLD. That is 34 clks at the defaults.
- Back-to-back transfers: the next POP occurs no earlier than GAP exit.
Other rules:
- Bit counter width is clog2(DATA_W+1); it is reset in LATCH.
- tx_valid dropping after IDLE has no effect; the byte is consumed in LATCH only.
- miso is used as-is; synchronisation is the responsibility of the pad wrapper.

Decomposition:
- Shared bridge package: state enum encoding, SPI mode constant (mode 0), default CLK_DIV, and the slave-address width constant (8) shared with the queue.
- One natural sub-module, spi_sclk_gen. It owns the CLK_DIV half-period counter and emits phase_done, rise and fall strobes plus sclk.
- The FSM and the shift registers stay in spi_xfer_engine.

Test Plan:
- Reset mid-SHIFT_HI: cs_n=all 1, sclk=0 asynchronously; no rx_valid; after release, busy=0.
- Single transfer: queue holds addr 3, tx_data=0xA5, miso replays 0x3C. Expected: q_rd_en pulses once, cs_n=8'b1111_0111 for 34 clks, mosi bits at rising edges = 1,0,1,0,0,1,0,1, then rx_valid with rx_data=0x3C, rx_err=0.
- Out-of-range: addr 9 with NUM_SLAVES=8. Expected: tx_ready pulse, rx_valid with rx_err=1, rx_data=0x00, cs_n never low, sclk static 0.
- Empty guard: q_empty=1, tx_valid=1 for 50 clks. Expected: q_rd_en never asserted, busy=0. Then deassert q_empty: POP occurs 1 clk later.
- Back-to-back: queue holds addrs 0 then 7, tx_valid held. Expected: two transfers, cs_n high for >= CLK_DIV+2 clks between them, cs_n[0] then cs_n[7] low, two tx_ready and two rx_valid pulses.
- CLK_DIV=1, DATA_W=8: sclk period = 2 clks, cs_n low for 17 clks, rx_data matches miso pattern 0xFF then 0x00.
